// File: rtl/apu_issue_queue.sv
// APU issue queue: buffers CPU APU requests in a circular FIFO toward a vector backend,
// tracks in-flight instructions and returns in-order completions to the CPU.
module apu_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int NOPS    = 3,
  parameter int OP_W    = 6,
  parameter int FLAGS_W = 15
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       apu_req,
  input  logic [NOPS*DATA_W-1:0]     apu_operands_i,
  input  logic [OP_W-1:0]            apu_op,
  input  logic [FLAGS_W-1:0]         apu_flags_i,
  output logic                       apu_gnt,
  output logic                       apu_rvalid,
  output logic [DATA_W-1:0]          apu_result,
  output logic [4:0]                 apu_flags_o,
  output logic                       issue_valid_o,
  input  logic                       issue_ready_i,
  output logic [OP_W-1:0]            issue_op_o,
  output logic [NOPS*DATA_W-1:0]     issue_operands_o,
  output logic [FLAGS_W-1:0]         issue_flags_o,
  input  logic                       cmpl_valid_i,
  input  logic [DATA_W-1:0]          cmpl_result_i,
  input  logic [4:0]                 cmpl_flags_i,
  output logic                       core_halt_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       cmpl_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = OP_W + NOPS*DATA_W + FLAGS_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [EW-1:0]     mem_q [DEPTH];
  logic [EW-1:0]     mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     occ_q, occ_d;
  logic [CW-1:0]     infl_q, infl_d;
  logic [CW-1:0]     count_q, count_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [4:0]        rflags_q, rflags_d;
  logic              halt_q, halt_d;
  logic              err_q, err_d;

  logic push_s;
  logic pop_s;
  logic cmpl_acc_s;

  // Grant depends only on registered count, so a freed slot is visible one cycle later.
  assign apu_gnt    = apu_req & (count_q < DEPTH_C);
  assign push_s     = apu_gnt;
  assign pop_s      = (occ_q != {CW{1'b0}}) & issue_ready_i;
  assign cmpl_acc_s = cmpl_valid_i & (infl_q != {CW{1'b0}});

  assign issue_valid_o = (occ_q != {CW{1'b0}});
  assign {issue_op_o, issue_operands_o, issue_flags_o} = mem_q[rd_ptr_q];

  assign apu_rvalid  = rvalid_q;
  assign apu_result  = result_q;
  assign apu_flags_o = rflags_q;
  assign core_halt_o = halt_q;
  assign count_o     = count_q;
  assign cmpl_err_o  = err_q;

  // Next-state computation for FIFO storage, pointers, counters and result path.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    infl_d   = infl_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = {apu_op, apu_operands_i, apu_flags_i};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
    case ({pop_s, cmpl_acc_s})
      2'b10:   infl_d = infl_q + CW'(1);
      2'b01:   infl_d = infl_q - CW'(1);
      default: infl_d = infl_q;
    endcase
    count_d  = occ_d + infl_d;
    halt_d   = (count_d == DEPTH_C);
    rvalid_d = cmpl_acc_s;
    if (cmpl_acc_s) begin
      result_d = cmpl_result_i;
      rflags_d = cmpl_flags_i;
    end else begin
      result_d = result_q;
      rflags_d = rflags_q;
    end
    err_d = err_q | (cmpl_valid_i & ~cmpl_acc_s);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {EW{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      occ_q    <= {CW{1'b0}};
      infl_q   <= {CW{1'b0}};
      count_q  <= {CW{1'b0}};
      rvalid_q <= 1'b0;
      result_q <= {DATA_W{1'b0}};
      rflags_q <= 5'b00000;
      halt_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      infl_q   <= infl_d;
      count_q  <= count_d;
      rvalid_q <= rvalid_d;
      result_q <= result_d;
      rflags_q <= rflags_d;
      halt_q   <= halt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_apu_issue_queue.sv
// Bench for apu_issue_queue: table of directed vectors plus a queue-based scoreboard
// monitor, then random wrap streaming and a mid-stream reset sequence.
module tb_apu_issue_queue;

  logic         clk = 1'b0;
  logic         n_reset = 1'b0;
  logic         apu_req = 1'b0;
  logic [95:0]  apu_operands_i = 96'd0;
  logic [5:0]   apu_op = 6'd0;
  logic [14:0]  apu_flags_i = 15'd0;
  logic         apu_gnt, apu_rvalid;
  logic [31:0]  apu_result;
  logic [4:0]   apu_flags_o;
  logic         issue_valid_o;
  logic         issue_ready_i = 1'b0;
  logic [5:0]   issue_op_o;
  logic [95:0]  issue_operands_o;
  logic [14:0]  issue_flags_o;
  logic         cmpl_valid_i = 1'b0;
  logic [31:0]  cmpl_result_i = 32'd0;
  logic [4:0]   cmpl_flags_i = 5'd0;
  logic         core_halt_o;
  logic [2:0]   count_o;
  logic         cmpl_err_o;

  always #5 clk = ~clk;

  apu_issue_queue dut (
    .clk(clk), .n_reset(n_reset), .apu_req(apu_req), .apu_operands_i(apu_operands_i),
    .apu_op(apu_op), .apu_flags_i(apu_flags_i), .apu_gnt(apu_gnt), .apu_rvalid(apu_rvalid),
    .apu_result(apu_result), .apu_flags_o(apu_flags_o), .issue_valid_o(issue_valid_o),
    .issue_ready_i(issue_ready_i), .issue_op_o(issue_op_o), .issue_operands_o(issue_operands_o),
    .issue_flags_o(issue_flags_o), .cmpl_valid_i(cmpl_valid_i), .cmpl_result_i(cmpl_result_i),
    .cmpl_flags_i(cmpl_flags_i), .core_halt_o(core_halt_o), .count_o(count_o), .cmpl_err_o(cmpl_err_o)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic [95:0] opnd;
    logic [14:0] fl;
  } ent_t;

  typedef struct {
    logic        req;
    logic [5:0]  op;
    logic [31:0] base;
    logic        rdy;
    logic        cv;
    logic [31:0] cres;
    logic        exp_gnt;
    logic [2:0]  exp_cnt;
    logic        exp_halt;
    logic        exp_rv;
    logic        exp_err;
  } vec_t;

  int          n_checks = 0;
  int          n_err = 0;
  ent_t        iss_q[$];
  int          mdl_infl = 0;
  logic        mdl_err = 1'b0;
  logic        exp_rv = 1'b0;
  logic [31:0] last_res = 32'd0;
  logic [4:0]  last_fl = 5'd0;
  int          acc_cnt = 0;
  int          rv_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [5:0] op, input logic [95:0] opnd,
                       input logic rdy, input logic cv, input logic [31:0] cres);
    apu_req        = req;
    apu_op         = op;
    apu_operands_i = opnd;
    apu_flags_i    = {9'd0, op} ^ 15'h2A00;
    issue_ready_i  = rdy;
    cmpl_valid_i   = cv;
    cmpl_result_i  = cres;
    cmpl_flags_i   = cres[4:0] ^ 5'h15;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic req, input logic [5:0] op, input logic [31:0] base,
                              input logic rdy, input logic cv, input logic [31:0] cres,
                              input logic g, input logic [2:0] c, input logic h,
                              input logic rv, input logic e);
    vec_t v;
    v.req = req; v.op = op; v.base = base; v.rdy = rdy; v.cv = cv; v.cres = cres;
    v.exp_gnt = g; v.exp_cnt = c; v.exp_halt = h; v.exp_rv = rv; v.exp_err = e;
    return v;
  endfunction

  // Scoreboard monitor: checks pre-edge outputs against the model, then advances the model.
  initial begin
    int   cnt;
    logic pop_m, cmpl_m;
    forever begin
      @(posedge clk);
      if (!n_reset) begin
        iss_q.delete();
        mdl_infl = 0; mdl_err = 1'b0; exp_rv = 1'b0; last_res = 32'd0; last_fl = 5'd0;
      end else begin
        cnt = iss_q.size() + mdl_infl;
        chk("mon_gnt", 128'(apu_gnt), 128'(apu_req && (cnt < 4)));
        chk("mon_count", 128'(count_o), 128'(cnt));
        chk("mon_halt", 128'(core_halt_o), 128'(cnt == 4));
        chk("mon_err", 128'(cmpl_err_o), 128'(mdl_err));
        chk("mon_rvalid", 128'(apu_rvalid), 128'(exp_rv));
        chk("mon_result", 128'(apu_result), 128'(last_res));
        chk("mon_rflags", 128'(apu_flags_o), 128'(last_fl));
        chk("mon_issue_valid", 128'(issue_valid_o), 128'(iss_q.size() != 0));
        if (iss_q.size() != 0 && issue_valid_o)
          chk("mon_issue_head", 128'({issue_op_o, issue_operands_o, issue_flags_o}), 128'(iss_q[0]));
        if (apu_rvalid) rv_cnt++;
        pop_m  = (iss_q.size() != 0) && issue_ready_i;
        cmpl_m = cmpl_valid_i && (mdl_infl > 0);
        if (cmpl_valid_i && mdl_infl == 0) mdl_err = 1'b1;
        exp_rv = cmpl_m;
        if (cmpl_m) begin
          last_res = cmpl_result_i;
          last_fl  = cmpl_flags_i;
        end
        if (pop_m) void'(iss_q.pop_front());
        if (apu_req && cnt < 4) begin
          iss_q.push_back({apu_op, apu_operands_i, apu_flags_i});
          acc_cnt++;
        end
        if (pop_m) mdl_infl++;
        if (cmpl_m) mdl_infl--;
      end
    end
  end

  initial begin
    vec_t tbl[21];
    int   rv_base, acc_base;

    // single op, fill to full, drain, full-then-free, simultaneous events, spurious completion
    tbl[0]  = mk(1'b1, 6'h05, 32'd1,   1'b1, 1'b0, 32'd0,        1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 6'h00, 32'd0,   1'b1, 1'b0, 32'd0,        1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 6'h00, 32'd0,   1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 6'h00, 32'd0,   1'b0, 1'b0, 32'd0,        1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 6'd10, 32'd16,  1'b0, 1'b0, 32'd0,        1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 6'd11, 32'd32,  1'b0, 1'b0, 32'd0,        1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 6'd12, 32'd48,  1'b0, 1'b0, 32'd0,        1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(1'b1, 6'd13, 32'd64,  1'b0, 1'b0, 32'd0,        1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 6'd14, 32'd80,  1'b0, 1'b0, 32'd0,        1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 6'h00, 32'd0,   1'b1, 1'b0, 32'd0,        1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 6'd15, 32'd96,  1'b1, 1'b1, 32'h000000A1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
    tbl[11] = mk(1'b1, 6'd15, 32'd96,  1'b0, 1'b0, 32'd0,        1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 6'h00, 32'd0,   1'b0, 1'b1, 32'h000000A2, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
    tbl[13] = mk(1'b0, 6'h00, 32'd0,   1'b1, 1'b0, 32'd0,        1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(1'b0, 6'h00, 32'd0,   1'b1, 1'b0, 32'd0,        1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    tbl[15] = mk(1'b0, 6'h00, 32'd0,   1'b0, 1'b1, 32'h000000A3, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
    tbl[16] = mk(1'b1, 6'd16, 32'd112, 1'b1, 1'b1, 32'h000000A4, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
    tbl[17] = mk(1'b0, 6'h00, 32'd0,   1'b1, 1'b1, 32'h000000A5, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0);
    tbl[18] = mk(1'b0, 6'h00, 32'd0,   1'b0, 1'b1, 32'h000000A6, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    tbl[19] = mk(1'b0, 6'h00, 32'd0,   1'b0, 1'b1, 32'h00000BAD, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    tbl[20] = mk(1'b0, 6'h00, 32'd0,   1'b0, 1'b0, 32'd0,        1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

    drive(1'b0, 6'd0, 96'd0, 1'b0, 1'b0, 32'd0);
    step();
    chk("reset_count", 128'(count_o), 128'(3'd0));
    chk("reset_issue_valid", 128'(issue_valid_o), 128'(1'b0));
    chk("reset_halt", 128'(core_halt_o), 128'(1'b0));
    step();
    n_reset = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].req, tbl[i].op, {tbl[i].base + 32'd2, tbl[i].base + 32'd1, tbl[i].base},
            tbl[i].rdy, tbl[i].cv, tbl[i].cres);
      #1;
      chk($sformatf("v%0d_gnt", i), 128'(apu_gnt), 128'(tbl[i].exp_gnt));
      step();
      chk($sformatf("v%0d_count", i), 128'(count_o), 128'(tbl[i].exp_cnt));
      chk($sformatf("v%0d_halt", i), 128'(core_halt_o), 128'(tbl[i].exp_halt));
      chk($sformatf("v%0d_rvalid", i), 128'(apu_rvalid), 128'(tbl[i].exp_rv));
      chk($sformatf("v%0d_err", i), 128'(cmpl_err_o), 128'(tbl[i].exp_err));
    end

    // random streaming across pointer wrap
    rv_base  = rv_cnt;
    acc_base = acc_cnt;
    for (int cyc = 0; cyc < 400 && (rv_cnt - rv_base) < 10; cyc++) begin
      drive((acc_cnt - acc_base) < 10, 6'($urandom), {$urandom, $urandom, $urandom},
            1'($urandom_range(0, 1)), (mdl_infl > 0) && ($urandom_range(0, 1) == 1), $urandom);
      step();
    end
    drive(1'b0, 6'd0, 96'd0, 1'b0, 1'b0, 32'd0);
    chk("wrap_accepts", 128'(acc_cnt - acc_base), 128'(10));
    chk("wrap_rvalids", 128'(rv_cnt - rv_base), 128'(10));
    chk("wrap_count", 128'(count_o), 128'(3'd0));

    // reset with three outstanding, then a completion that must be flagged spurious
    drive(1'b1, 6'd40, {32'd42, 32'd41, 32'd40}, 1'b0, 1'b0, 32'd0);
    step();
    drive(1'b1, 6'd41, {32'd52, 32'd51, 32'd50}, 1'b1, 1'b0, 32'd0);
    step();
    drive(1'b1, 6'd42, {32'd62, 32'd61, 32'd60}, 1'b0, 1'b0, 32'd0);
    step();
    chk("prereset_count", 128'(count_o), 128'(3'd3));
    drive(1'b0, 6'd0, 96'd0, 1'b0, 1'b0, 32'd0);
    n_reset = 1'b0;
    #1;
    chk("rst_count", 128'(count_o), 128'(3'd0));
    chk("rst_issue_valid", 128'(issue_valid_o), 128'(1'b0));
    chk("rst_rvalid", 128'(apu_rvalid), 128'(1'b0));
    chk("rst_result", 128'(apu_result), 128'(32'd0));
    chk("rst_rflags", 128'(apu_flags_o), 128'(5'd0));
    chk("rst_halt", 128'(core_halt_o), 128'(1'b0));
    chk("rst_err", 128'(cmpl_err_o), 128'(1'b0));
    step();
    n_reset = 1'b1;
    drive(1'b0, 6'd0, 96'd0, 1'b0, 1'b1, 32'h12345678);
    step();
    drive(1'b0, 6'd0, 96'd0, 1'b0, 1'b0, 32'd0);
    chk("postrst_err", 128'(cmpl_err_o), 128'(1'b1));
    chk("postrst_rvalid", 128'(apu_rvalid), 128'(1'b0));
    step();
    chk("postrst_err_sticky", 128'(cmpl_err_o), 128'(1'b1));
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/apu_issue_queue.md
APU_ISSUE_QUEUE -- requirements
Module: apu_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set request-queue entries and the maximum outstanding instructions; it SHALL be a power of 2 and at least 2.
REQ-002 Parameter DATA_W, default 32, SHALL set the operand and result width.
REQ-003 Parameter NOPS, default 3, SHALL set the operand count per request.
REQ-004 Parameter OP_W, default 6, SHALL set the opcode width.
REQ-005 Parameter FLAGS_W, default 15, SHALL set the input flag width.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 n_reset  in  1  asynchronous, active-low reset.
REQ-008 apu_req  in  1  CPU request valid.
REQ-009 apu_operands_i  in  NOPS x DATA_W  request operands.
REQ-010 apu_op  in  OP_W  request opcode.
REQ-011 apu_flags_i  in  FLAGS_W  request flags.
REQ-012 apu_gnt  out  1  request accepted this cycle.
REQ-013 apu_rvalid  out  1  one-cycle result-valid pulse to the CPU.
REQ-014 apu_result  out  DATA_W  result to the CPU.
REQ-015 apu_flags_o  out  5  result flags to the CPU.
REQ-016 issue_valid_o  out  1  queue head valid toward the vector backend.
REQ-017 issue_ready_i  in  1  backend accepts the head.
REQ-018 issue_op_o, issue_operands_o, issue_flags_o  out  OP_W / NOPS x DATA_W / FLAGS_W  head contents.
REQ-019 cmpl_valid_i  in  1  backend completion strobe (in-order).
REQ-020 cmpl_result_i, cmpl_flags_i  in  DATA_W / 5  completion data.
REQ-021 core_halt_o  out  1  outstanding count equals DEPTH.
REQ-022 count_o  out  log2(DEPTH)+1  total outstanding (queued plus in flight).
REQ-023 cmpl_err_o  out  1  sticky: completion received with nothing in flight.

Function
REQ-024 apu_gnt SHALL be combinational and equal apu_req AND (count_o < DEPTH); a request is accepted exactly when apu_req and apu_gnt are both 1.
REQ-025 An accepted request SHALL be written to a circular FIFO (write pointer wraps modulo DEPTH) and SHALL be visible on issue_* no earlier than the next cycle (no bypass).
REQ-026 issue_valid_o SHALL be 1 when the FIFO is non-empty, and issue_* SHALL show the oldest entry, held stable until popped.
REQ-027 A pop SHALL occur when issue_valid_o AND issue_ready_i; the entry then moves to in-flight, and the read pointer wraps modulo DEPTH.
REQ-028 Push and pop in the same cycle SHALL both take effect, with FIFO occupancy unchanged; this includes the case of 1 entry.
REQ-029 inflight SHALL increment on pop and decrement on an accepted completion; pop and completion in the same cycle SHALL leave it unchanged.
REQ-030 count_o SHALL equal FIFO occupancy plus inflight, never exceeding DEPTH, and SHALL be updated in the cycle after the causing event.
REQ-031 A completion SHALL be accepted when cmpl_valid_i=1 and inflight>0.
REQ-032 When a completion is accepted, the next cycle SHALL show apu_rvalid=1, apu_result=cmpl_result_i and apu_flags_o=cmpl_flags_i (registered, latency 1).
REQ-033 apu_rvalid SHALL deassert in the following cycle unless another completion is accepted; apu_result and apu_flags_o SHALL hold their last values.
REQ-034 cmpl_valid_i with inflight=0 SHALL be ignored (no rvalid, counts unchanged) and SHALL set cmpl_err_o, which stays set until reset.
REQ-035 core_halt_o SHALL be registered and equal (count_o == DEPTH).
REQ-036 When full, a completion SHALL free the slot the next cycle: count_o drops, and apu_gnt may assert in that next cycle, not in the same cycle.

Reset
REQ-037 Asserting n_reset low SHALL immediately clear pointers, occupancy, inflight, count_o, apu_rvalid, apu_result, apu_flags_o, core_halt_o and cmpl_err_o; issue_valid_o SHALL go to 0.
REQ-038 Reset mid-operation SHALL discard all queued and in-flight instructions, and later completions SHALL be treated per REQ-034.

Verification
REQ-039 Single op: apu_req with op=6'h05, operands {1,2,3}, issue_ready_i=1 -> gnt same cycle, issue_valid_o next cycle, cmpl_result_i=32'hDEADBEEF -> apu_rvalid pulse with that value 1 cycle later; count_o back to 0.
REQ-040 Fill: issue_ready_i=0, 5 back-to-back requests, DEPTH=4 -> first 4 granted, 5th not; core_halt_o=1, count_o=4; FIFO order preserved when draining.
REQ-041 Wrap: 10 requests streamed with random issue_ready_i and completions -> issue order equals accept order across pointer wrap; 10 rvalid pulses in order.
REQ-042 Simultaneous events: push, pop and completion in one cycle with count_o=2 -> count_o stays 2, FIFO occupancy unchanged.
REQ-043 Spurious completion: cmpl_valid_i with count_o=0 -> no apu_rvalid, cmpl_err_o=1 sticky.
REQ-044 Reset mid-stream: 3 outstanding, n_reset pulse -> all outputs zero immediately; a following completion raises cmpl_err_o.
